// File: rtl/mux_arb_stream.sv
// N-input stream selector, forced-select or round-robin grant,
// one registered output stage with valid/ready on every channel.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_data[N*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_valid[N]       channel i holds a word
//   in_ready[N]       channel i's word accepted this cycle
//   mode              0 = forced select, 1 = round-robin
//   sel[SELW]         channel used when mode=0 (clamped to N-1)
//   out_data[WIDTH]   registered output word
//   out_valid         out_data holds a word
//   out_ready         consumer takes the word this cycle
//   out_src[SELW]     channel index out_data came from
module mux_arb_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  eff_sel;
  logic [SELW-1:0]  gnt;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_data;
  logic             load_en;
  logic             xfer;

  assign load_en = !out_valid || out_ready;

  // In-range sel passes through; anything >= N steers to the last channel.
  always_comb begin
    eff_sel = sel;
    if (int'(sel) >= N)
      eff_sel = SELW'(N - 1);
  end

  // Round-robin searches from the channel after the last winner.
  always_comb begin
    logic [SELW-1:0] idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    if (!mode) begin
      gnt     = eff_sel;
      gnt_vld = in_valid[eff_sel];
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = SELW'((int'(rr_ptr) + k) % N);
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i))
        gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Reset blocks acceptance so no word is lost in a reset cycle.
  assign xfer = load_en && gnt_vld && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (gnt == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_src   <= gnt;
        if (mode)
          rr_ptr <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_stream.sv
// Directed-vector bench for mux_arb_stream (N=3, WIDTH=8).
// Expected values are hand-computed per vector.
module tb_mux_arb_stream;

  logic        clk;
  logic        reset;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_src;

  int n_chk;
  int n_fail;

  logic [7:0] dv [3];
  logic [1:0] sv [4];
  logic [1:0] ev [4];
  logic [1:0] g4 [5];

  mux_arb_stream #(.WIDTH(8), .N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    dv[0] = 8'hA0; dv[1] = 8'hB1; dv[2] = 8'hC2;
    sv[0] = 2'd0; sv[1] = 2'd1; sv[2] = 2'd2; sv[3] = 2'd3;
    ev[0] = 2'd0; ev[1] = 2'd1; ev[2] = 2'd2; ev[3] = 2'd2;
    g4[0] = 2'd0; g4[1] = 2'd2; g4[2] = 2'd0; g4[3] = 2'd2;
    g4[4] = 2'd1;

    // T1 reset with all channels valid
    reset     = 1'b1;
    in_data   = {8'hC2, 8'hB1, 8'hA0};
    in_valid  = 3'b111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_data",  32'(out_data),  32'd0);
    chk("t1_rdy",   32'(in_ready),  32'd0);
    reset = 1'b0;

    // T2 forced select incl. out-of-range clamp
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = sv[i];
      settle();
      chk("t2_rdy", 32'(in_ready), 32'(3'b001 << ev[i]));
      tick();
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_data",  32'(out_data),  32'(dv[ev[i]]));
      chk("t2_src",   32'(out_src),   32'(ev[i]));
    end

    // T3 round-robin fairness; pointer still at 2
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("t3_rdy", 32'(in_ready), 32'(3'b001 << (i % 3)));
      tick();
      chk("t3_src",  32'(out_src),  32'(i % 3));
      chk("t3_data", 32'(out_data), 32'(dv[i % 3]));
    end

    // T4 skip and wrap, then only ch1
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4) ? 3'b101 : 3'b010;
      settle();
      chk("t4_rdy", 32'(in_ready), 32'(3'b001 << g4[i]));
      tick();
      chk("t4_src", 32'(out_src), 32'(g4[i]));
    end

    // T5 backpressure; pointer at 1 -> next grant 2
    in_valid = 3'b111;
    settle();
    tick();
    chk("t5_load_src", 32'(out_src), 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {8'h11, 8'h22, 8'h33};
      settle();
      chk("t5_rdy",   32'(in_ready),  32'd0);
      tick();
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_data",  32'(out_data),  32'hC2);
      chk("t5_src",   32'(out_src),   32'd2);
    end
    in_data   = {8'hC2, 8'hB1, 8'hA0};
    out_ready = 1'b1;
    settle();
    chk("t5_rel_rdy", 32'(in_ready), 32'b001);
    tick();
    chk("t5_rel_src",  32'(out_src),  32'd0);
    chk("t5_rel_data", 32'(out_data), 32'hA0);

    // T6 reset mid-stream; pointer was 0, reset returns it to 2
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    chk("t6_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    settle();
    chk("t6_rst_rdy", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("t6_rdy", 32'(in_ready), 32'b001);
    tick();
    chk("t6_src",  32'(out_src),  32'd0);
    chk("t6_data", 32'(out_data), 32'hA0);

    // Drain: no grant, consumer ready
    in_valid = 3'b000;
    settle();
    chk("dr_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("dr_valid", 32'(out_valid), 32'd0);
    chk("dr_data",  32'(out_data),  32'hA0);
    chk("dr_src",   32'(out_src),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
